// File: rtl/nf_enc_pkg.sv
// Shared types, RV32I opcode/funct constants and field-packing helpers for the instruction encoder.
package nf_enc_pkg;

  typedef enum logic [4:0] {
    OpAdd  = 5'd0,
    OpAnd  = 5'd1,
    OpSub  = 5'd2,
    OpSll  = 5'd3,
    OpOr   = 5'd4,
    OpAddi = 5'd5,
    OpOri  = 5'd6,
    OpSlli = 5'd7,
    OpLw   = 5'd8,
    OpJalr = 5'd9,
    OpLui  = 5'd10,
    OpBeq  = 5'd11,
    OpBne  = 5'd12,
    OpSw   = 5'd13,
    OpJal  = 5'd14,
    OpLi   = 5'd15,
    OpNop  = 5'd16
  } enc_op_t;

  typedef enum logic [0:0] {StIdle, StLi2} enc_state_t;

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcLui    = 7'b0110111;

  localparam logic [2:0] F3AddSub = 3'b000;
  localparam logic [2:0] F3Sll    = 3'b001;
  localparam logic [2:0] F3Word   = 3'b010;
  localparam logic [2:0] F3Or     = 3'b110;
  localparam logic [2:0] F3And    = 3'b111;
  localparam logic [2:0] F3Beq    = 3'b000;
  localparam logic [2:0] F3Bne    = 3'b001;

  localparam logic [6:0] F7Zero = 7'b0000000;
  localparam logic [6:0] F7Sub  = 7'b0100000;

  localparam logic [31:0] NopWord = 32'h0000_0013;

  function automatic logic [31:0] fmt_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] fmt_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] fmt_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [6:0] opc);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
  endfunction

  function automatic logic [31:0] fmt_b(input logic [12:1] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [6:0] opc);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
  endfunction

  function automatic logic [31:0] fmt_u(input logic [19:0] hi, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {hi, rd, opc};
  endfunction

  function automatic logic [31:0] fmt_j(input logic [20:1] imm, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
  endfunction

  // Signed value fits in `width` bits and is a multiple of 2**align.
  function automatic logic imm_fits(input logic [31:0] imm, input int unsigned width,
                                    input int unsigned align);
    logic [31:0] top;
    logic [31:0] mask;
    top  = $signed(imm) >>> (width - 1);
    mask = (32'd1 << align) - 32'd1;
    return ((top == '0) || (top == '1)) && ((imm & mask) == '0);
  endfunction

endpackage

// File: rtl/nf_enc_fmt.sv
// Combinational op/field -> instruction word(s) translation with immediate range checking.
module nf_enc_fmt
  import nf_enc_pkg::*;
(
  input  logic [4:0]  op_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word0_o,
  output logic [31:0] word1_o,
  output logic        two_word_o,
  output logic        illegal_o
);

  enc_op_t     op;
  logic [19:0] li_hi;
  logic        fits_i12;

  assign op       = enc_op_t'(op_i);
  // Upper part is rounded up when the low 12 bits sign-extend negative.
  assign li_hi    = imm_i[31:12] + {19'd0, imm_i[11]};
  assign fits_i12 = imm_fits(imm_i, 12, 0);

  always_comb begin
    word0_o    = NopWord;
    word1_o    = '0;
    two_word_o = 1'b0;
    illegal_o  = 1'b0;
    case (op)
      OpAdd:  word0_o = fmt_r(F7Zero, rs2_i, rs1_i, F3AddSub, rd_i, OpcOp);
      OpSub:  word0_o = fmt_r(F7Sub, rs2_i, rs1_i, F3AddSub, rd_i, OpcOp);
      OpAnd:  word0_o = fmt_r(F7Zero, rs2_i, rs1_i, F3And, rd_i, OpcOp);
      OpSll:  word0_o = fmt_r(F7Zero, rs2_i, rs1_i, F3Sll, rd_i, OpcOp);
      OpOr:   word0_o = fmt_r(F7Zero, rs2_i, rs1_i, F3Or, rd_i, OpcOp);
      OpAddi: begin
        word0_o   = fmt_i(imm_i[11:0], rs1_i, F3AddSub, rd_i, OpcOpImm);
        illegal_o = !fits_i12;
      end
      OpOri: begin
        word0_o   = fmt_i(imm_i[11:0], rs1_i, F3Or, rd_i, OpcOpImm);
        illegal_o = !fits_i12;
      end
      OpSlli: begin
        word0_o   = fmt_r(F7Zero, imm_i[4:0], rs1_i, F3Sll, rd_i, OpcOpImm);
        illegal_o = |imm_i[31:5];
      end
      OpLw: begin
        word0_o   = fmt_i(imm_i[11:0], rs1_i, F3Word, rd_i, OpcLoad);
        illegal_o = !fits_i12;
      end
      OpJalr: begin
        word0_o   = fmt_i(imm_i[11:0], rs1_i, F3AddSub, rd_i, OpcJalr);
        illegal_o = !fits_i12;
      end
      OpSw: begin
        word0_o   = fmt_s(imm_i[11:0], rs2_i, rs1_i, F3Word, OpcStore);
        illegal_o = !fits_i12;
      end
      OpLui: begin
        word0_o   = fmt_u(imm_i[31:12], rd_i, OpcLui);
        illegal_o = |imm_i[11:0];
      end
      OpBeq: begin
        word0_o   = fmt_b(imm_i[12:1], rs2_i, rs1_i, F3Beq, OpcBranch);
        illegal_o = !imm_fits(imm_i, 13, 1);
      end
      OpBne: begin
        word0_o   = fmt_b(imm_i[12:1], rs2_i, rs1_i, F3Bne, OpcBranch);
        illegal_o = !imm_fits(imm_i, 13, 1);
      end
      OpJal: begin
        word0_o   = fmt_j(imm_i[20:1], rd_i, OpcJal);
        illegal_o = !imm_fits(imm_i, 21, 1);
      end
      OpLi: begin
        if (fits_i12) begin
          word0_o = fmt_i(imm_i[11:0], 5'd0, F3AddSub, rd_i, OpcOpImm);
        end else begin
          word0_o    = fmt_u(li_hi, rd_i, OpcLui);
          word1_o    = fmt_i(imm_i[11:0], rd_i, F3AddSub, rd_i, OpcOpImm);
          two_word_o = 1'b1;
        end
      end
      OpNop:   word0_o = NopWord;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/nf_instr_encoder.sv
// RV32I instruction encoder: request handshake, LI two-word sequencing and registered output stage.
module nf_instr_encoder
  import nf_enc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_vld,
  output logic        req_rdy,
  input  logic [4:0]  req_op,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic [31:0] req_imm,
  output logic        instr_vld,
  input  logic        instr_rdy,
  output logic [31:0] instr,
  output logic        err
);

  enc_state_t  state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pend_q, pend_d;
  logic        vld_q, vld_d;
  logic        err_q, err_d;

  logic [31:0] word0, word1;
  logic        two_word, illegal;
  logic        accept, xfer;

  nf_enc_fmt u_fmt (
    .op_i       (req_op),
    .rd_i       (req_rd),
    .rs1_i      (req_rs1),
    .rs2_i      (req_rs2),
    .imm_i      (req_imm),
    .word0_o    (word0),
    .word1_o    (word1),
    .two_word_o (two_word),
    .illegal_o  (illegal)
  );

  assign req_rdy = (state_q == StIdle) && (!vld_q || instr_rdy);
  assign accept  = req_vld && req_rdy;
  assign xfer    = vld_q && instr_rdy;

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    pend_d  = pend_q;
    vld_d   = vld_q;
    err_d   = 1'b0;
    if (xfer) begin
      vld_d = 1'b0;
    end
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (illegal) begin
            err_d = 1'b1;
          end else begin
            instr_d = word0;
            vld_d   = 1'b1;
            if (two_word) begin
              pend_d  = word1;
              state_d = StLi2;
            end
          end
        end
      end
      StLi2: begin
        // The LUI half is always held here, so a transfer hands over to the ADDI half.
        if (xfer) begin
          instr_d = pend_q;
          vld_d   = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      instr_q <= '0;
      pend_q  <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pend_q  <= pend_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  assign instr     = instr_q;
  assign instr_vld = vld_q;
  assign err       = err_q;

endmodule

// File: tb/tb_nf_instr_encoder.sv
// Self-checking bench: arithmetic reference encoder plus a per-cycle scoreboard and directed vectors.
module tb_nf_instr_encoder;
  import nf_enc_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_vld = 1'b0;
  logic        req_rdy;
  logic [4:0]  req_op = '0;
  logic [4:0]  req_rd = '0;
  logic [4:0]  req_rs1 = '0;
  logic [4:0]  req_rs2 = '0;
  logic [31:0] req_imm = '0;
  logic        instr_vld;
  logic        instr_rdy = 1'b1;
  logic [31:0] instr;
  logic        err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int errs_seen = 0;
  logic [31:0] mq[$];
  logic [31:0] got[$];
  int gcyc[$];
  bit err_pend = 1'b0;

  nf_instr_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .req_vld   (req_vld),
    .req_rdy   (req_rdy),
    .req_op    (req_op),
    .req_rd    (req_rd),
    .req_rs1   (req_rs1),
    .req_rs2   (req_rs2),
    .req_imm   (req_imm),
    .instr_vld (instr_vld),
    .instr_rdy (instr_rdy),
    .instr     (instr),
    .err       (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Places the low w bits of val at bit position lsb.
  function automatic bit [31:0] fld(input longint val, input int w, input int lsb);
    longint m;
    m = (longint'(1) << w) - 1;
    return 32'((val & m) << lsb);
  endfunction

  function automatic bit [31:0] itype(input longint imm, input int rs1, input int f3,
                                      input int rd, input int opc);
    return fld(imm, 12, 20) | fld(rs1, 5, 15) | fld(f3, 3, 12) | fld(rd, 5, 7) | fld(opc, 7, 0);
  endfunction

  function automatic bit [31:0] rtype(input int f7, input int rs2, input int rs1, input int f3,
                                      input int rd);
    return fld(f7, 7, 25) | fld(rs2, 5, 20) | itype(0, rs1, f3, rd, 51);
  endfunction

  function automatic bit [31:0] btype(input longint v, input int rs2, input int rs1, input int f3);
    return fld(v >>> 12, 1, 31) | fld(v >>> 5, 6, 25) | fld(rs2, 5, 20) | fld(rs1, 5, 15) |
           fld(f3, 3, 12) | fld(v >>> 1, 4, 8) | fld(v >>> 11, 1, 7) | 32'd99;
  endfunction

  // Reference: number of words, the words, and whether the request is rejected.
  task automatic model(input logic [4:0] op, input int rd, input int rs1, input int rs2,
                       input int imm, output int n, output bit [31:0] w0, output bit [31:0] w1,
                       output bit e);
    longint v, lo_s, hi;
    bit i12;
    v = imm;
    n = 1; w0 = 0; w1 = 0; e = 0;
    i12 = (v >= -2048) && (v <= 2047);
    case (op)
      OpAdd:  w0 = rtype(0, rs2, rs1, 0, rd);
      OpSub:  w0 = rtype(32, rs2, rs1, 0, rd);
      OpAnd:  w0 = rtype(0, rs2, rs1, 7, rd);
      OpSll:  w0 = rtype(0, rs2, rs1, 1, rd);
      OpOr:   w0 = rtype(0, rs2, rs1, 6, rd);
      OpAddi: begin w0 = itype(v, rs1, 0, rd, 19); e = !i12; end
      OpOri:  begin w0 = itype(v, rs1, 6, rd, 19); e = !i12; end
      OpSlli: begin w0 = itype(v, rs1, 1, rd, 19); e = (v < 0) || (v > 31); end
      OpLw:   begin w0 = itype(v, rs1, 2, rd, 3); e = !i12; end
      OpJalr: begin w0 = itype(v, rs1, 0, rd, 103); e = !i12; end
      OpSw: begin
        w0 = fld(v >>> 5, 7, 25) | fld(rs2, 5, 20) | fld(rs1, 5, 15) | fld(2, 3, 12) |
             fld(v, 5, 7) | 32'd35;
        e = !i12;
      end
      OpLui: begin w0 = fld(v >>> 12, 20, 12) | fld(rd, 5, 7) | 32'd55; e = (v & 'hFFF) != 0; end
      OpBeq, OpBne: begin
        w0 = btype(v, rs2, rs1, (op == OpBne) ? 1 : 0);
        e = (v < -4096) || (v > 4094) || ((v & 1) != 0);
      end
      OpJal: begin
        w0 = fld(v >>> 20, 1, 31) | fld(v >>> 1, 10, 21) | fld(v >>> 11, 1, 20) |
             fld(v >>> 12, 8, 12) | fld(rd, 5, 7) | 32'd111;
        e = (v < -1048576) || (v > 1048574) || ((v & 1) != 0);
      end
      OpLi: begin
        if (i12) begin
          w0 = itype(v, 0, 0, rd, 19);
        end else begin
          lo_s = ((v & 'hFFF) ^ 'h800) - 'h800;
          hi   = (v - lo_s) >>> 12;
          w0   = fld(hi, 20, 12) | fld(rd, 5, 7) | 32'd55;
          w1   = itype(lo_s, rd, 0, rd, 19);
          n    = 2;
        end
      end
      OpNop: w0 = 32'h13;
      default: e = 1;
    endcase
  endtask

  always @(negedge clk) begin
    int n;
    bit [31:0] w0, w1;
    bit e;
    if (rst) begin
      mq.delete();
      err_pend = 1'b0;
      chk("rst_instr_vld", {31'd0, instr_vld}, 32'd0);
    end else begin
      chk("err", {31'd0, err}, {31'd0, err_pend});
      if (err) errs_seen++;
      chk("instr_vld", {31'd0, instr_vld}, {31'd0, mq.size() != 0});
      chk("req_rdy", {31'd0, req_rdy},
          {31'd0, (mq.size() < 2) && (mq.size() == 0 || instr_rdy)});
      if (instr_vld && mq.size() != 0) chk("instr", instr, mq[0]);
      if (instr_vld && instr_rdy) begin
        got.push_back(instr);
        gcyc.push_back(cyc);
        if (mq.size() != 0) void'(mq.pop_front());
      end
      err_pend = 1'b0;
      if (req_vld && req_rdy) begin
        model(req_op, int'(req_rd), int'(req_rs1), int'(req_rs2), int'(req_imm), n, w0, w1, e);
        if (e) begin
          err_pend = 1'b1;
        end else begin
          mq.push_back(w0);
          if (n == 2) mq.push_back(w1);
        end
      end
    end
  end

  task automatic send(input logic [4:0] op, input int rd, input int rs1, input int rs2,
                      input int imm);
    bit ok;
    ok = 1'b0;
    req_op = op; req_rd = 5'(rd); req_rs1 = 5'(rs1); req_rs2 = 5'(rs2); req_imm = imm;
    req_vld = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (req_rdy) ok = 1'b1;
    end
    @(posedge clk);
    #1;
    req_vld = 1'b0;
    chk("send_accept", {31'd0, ok}, 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_got(input string name, input int idx, input logic [31:0] exp);
    if (got.size() > idx) chk(name, got[idx], exp);
    else chk({name, "_missing"}, 32'(got.size()), 32'(idx + 1));
  endtask

  initial begin
    int n;
    bit [31:0] w0, w1;
    bit e;
    int e0;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("reset_instr_vld", {31'd0, instr_vld}, 32'd0);
    chk("reset_instr", instr, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);
    chk("reset_req_rdy", {31'd0, req_rdy}, 32'd1);

    model(OpAdd, 3, 1, 2, 0, n, w0, w1, e);   chk("pin_add", w0, 32'h002081B3);
    model(OpSub, 3, 1, 2, 0, n, w0, w1, e);   chk("pin_sub", w0, 32'h402081B3);
    model(OpBeq, 0, 1, 2, -4, n, w0, w1, e);  chk("pin_beq", w0, 32'hFE208EE3);
    model(OpLi, 5, 0, 0, 32'h12345FFF, n, w0, w1, e);
    chk("pin_li_n", 32'(n), 32'd2);
    chk("pin_li_w0", w0, 32'h123462B7);
    chk("pin_li_w1", w1, 32'hFFF28293);
    model(OpAddi, 1, 0, 0, 2048, n, w0, w1, e); chk("pin_addi_err", {31'd0, e}, 32'd1);
    @(posedge clk);
    #1;

    // Back-to-back R-type
    got.delete(); gcyc.delete();
    send(OpAdd, 3, 1, 2, 0);
    send(OpSub, 3, 1, 2, 0);
    idle(3);
    chk_got("t1_add", 0, 32'h002081B3);
    chk_got("t1_sub", 1, 32'h402081B3);
    if (gcyc.size() >= 2) chk("t1_gap", 32'(gcyc[1] - gcyc[0]), 32'd1);

    // Branch held under backpressure
    got.delete();
    instr_rdy = 1'b0;
    send(OpBeq, 0, 1, 2, -4);
    repeat (3) begin
      @(negedge clk);
      chk("t2_hold_instr", instr, 32'hFE208EE3);
      chk("t2_hold_rdy", {31'd0, req_rdy}, 32'd0);
    end
    @(posedge clk);
    #1;
    instr_rdy = 1'b1;
    idle(2);
    chk_got("t2_beq", 0, 32'hFE208EE3);
    chk("t2_count", 32'(got.size()), 32'd1);

    // Two-word LI
    got.delete();
    send(OpLi, 5, 0, 0, 32'h12345FFF);
    @(negedge clk);
    chk("t3_li2_rdy", {31'd0, req_rdy}, 32'd0);
    idle(3);
    chk_got("t3_lui", 0, 32'h123462B7);
    chk_got("t3_addi", 1, 32'hFFF28293);

    // Single-word LI
    got.delete();
    send(OpLi, 1, 0, 0, 5);
    idle(3);
    chk_got("t4_li", 0, 32'h00500093);
    chk("t4_count", 32'(got.size()), 32'd1);

    // Rejected requests then a normal one
    got.delete();
    e0 = errs_seen;
    send(OpAddi, 1, 0, 0, 2048);
    send(OpBeq, 0, 1, 2, 3);
    send(OpSlli, 1, 1, 0, 32);
    send(5'd20, 1, 1, 1, 0);
    send(OpJal, 1, 0, 0, 1048576);
    send(OpLui, 1, 0, 0, 32'h00001001);
    send(OpSw, 0, 2, 9, -2049);
    send(OpBne, 0, 3, 4, 4096);
    send(OpAdd, 3, 1, 2, 0);
    idle(3);
    chk("t5_errs", 32'(errs_seen - e0), 32'd8);
    chk_got("t5_after", 0, 32'h002081B3);
    chk("t5_count", 32'(got.size()), 32'd1);

    // Legal boundaries and remaining ops, checked against the reference by the monitor
    send(OpAnd, 4, 5, 6, 0);
    send(OpOr, 7, 8, 9, 0);
    send(OpSll, 10, 11, 12, 0);
    send(OpAddi, 1, 2, 0, -2048);
    send(OpOri, 3, 4, 0, 2047);
    send(OpSlli, 5, 6, 0, 31);
    send(OpLw, 7, 2, 0, -4);
    send(OpSw, 0, 2, 9, 2047);
    send(OpJalr, 1, 5, 0, -2048);
    send(OpLui, 8, 0, 0, 32'hFFFFF000);
    send(OpBne, 0, 3, 4, 4094);
    send(OpBeq, 0, 3, 4, -4096);
    send(OpJal, 1, 0, 0, -1048576);
    send(OpJal, 1, 0, 0, 1048574);
    send(OpLi, 6, 0, 0, -2049);
    send(OpLi, 6, 0, 0, 32'h80000000);
    idle(4);

    // Reset while the LUI half is stalled
    instr_rdy = 1'b0;
    send(OpLi, 5, 0, 0, 32'h12345FFF);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_rst_vld", {31'd0, instr_vld}, 32'd0);
    idle(2);
    rst = 1'b0;
    instr_rdy = 1'b1;
    got.delete();
    send(OpNop, 0, 0, 0, 0);
    idle(3);
    chk_got("t6_nop", 0, 32'h00000013);
    chk("t6_count", 32'(got.size()), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
